// File: rtl/addsub_pkg.sv
// ----------------------------------------------------------------------------
// addsub_pkg
// Shared types and constants for the digit-serial adder/subtractor.
//   flags_t   : packed {n, z, c, v}, same bit order as the flags port
//   state_t   : controller states IDLE / RUN / DONE
//   FLAG_*    : bit positions of each flag inside the 4-bit flags port
//   cnt_width : width of the digit counter for a given digit count
// ----------------------------------------------------------------------------
package addsub_pkg;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        DONE = ST_DONE
    } state_t;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

    // A single-digit operation still needs a 1-bit counter.
    function automatic int cnt_width(input int ndig);
        return (ndig > 1) ? $clog2(ndig) : 1;
    endfunction

endpackage

// File: rtl/addsub_digit.sv
// ----------------------------------------------------------------------------
// addsub_digit
// Combinational DIGIT-bit ripple adder built from fullAdder_1bit cells.
//   a_dig, b_dig : digit operands (b already inverted for subtraction)
//   cin          : carry into the digit LSB
//   sum_dig      : digit sum
//   cout         : carry out of the digit MSB
//   c_msb_in     : carry into the digit MSB (for signed overflow)
// ----------------------------------------------------------------------------
module addsub_digit #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a_dig,
    input  logic [DIGIT-1:0] b_dig,
    input  logic             cin,
    output logic [DIGIT-1:0] sum_dig,
    output logic             cout,
    output logic             c_msb_in
);

    logic [DIGIT:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < DIGIT; i++) begin : g_fa
        fullAdder_1bit u_fa (
            .a_i   (a_dig[i]),
            .b_i   (b_dig[i]),
            .cin_i (carry[i]),
            .sum_o (sum_dig[i]),
            .cout_o(carry[i+1])
        );
    end

    assign cout     = carry[DIGIT];
    assign c_msb_in = carry[DIGIT-1];

endmodule

// File: rtl/fullAdder_1bit.sv
// ----------------------------------------------------------------------------
// fullAdder_1bit
// Single-bit full adder cell.
//   a_i, b_i, cin_i : addend bits and carry in
//   sum_o, cout_o   : sum bit and carry out
// ----------------------------------------------------------------------------
module fullAdder_1bit (
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    output logic sum_o,
    output logic cout_o
);

    assign sum_o  = a_i ^ b_i ^ cin_i;
    assign cout_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));

endmodule

// File: rtl/addsub_serial.sv
// ----------------------------------------------------------------------------
// addsub_serial
// Digit-serial adder/subtractor with ARM-style NZCV flags. One DIGIT-wide
// slice is added per clock, LSB digit first, so an operation takes
// WIDTH/DIGIT RUN cycles. Subtraction is a + ~b + 1 (C is NOT-borrow).
//   clk, reset_n         : clock, synchronous active-low reset
//   in_valid / in_ready  : operand handshake (a, b, sub sampled on accept)
//   out_valid / out_ready: result handshake; result/flags held until taken
//   result               : a +/- b modulo 2^WIDTH
//   flags                : {N, Z, C, V}
// ----------------------------------------------------------------------------
module addsub_serial
    import addsub_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = cnt_width(NDIG);
    localparam logic [CW-1:0] LAST_CNT = CW'(NDIG - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic             zero_q, zero_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    flags_t           flags_q, flags_d;

    logic [DIGIT-1:0] sum_dig;
    logic             dig_cout;
    logic             dig_c_msb_in;
    logic [WIDTH-1:0] res_shift;
    logic             accept;
    logic             last_digit;

    // Outputs are pure state decodes or registers: no input-to-output path.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = res_q;

    assign flags[FLAG_N] = flags_q.n;
    assign flags[FLAG_Z] = flags_q.z;
    assign flags[FLAG_C] = flags_q.c;
    assign flags[FLAG_V] = flags_q.v;

    assign accept     = in_valid && in_ready;
    assign last_digit = (cnt_q == LAST_CNT);

    addsub_digit #(.DIGIT(DIGIT)) u_digit (
        .a_dig   (a_q[DIGIT-1:0]),
        .b_dig   (b_q[DIGIT-1:0]),
        .cin     (carry_q),
        .sum_dig (sum_dig),
        .cout    (dig_cout),
        .c_msb_in(dig_c_msb_in)
    );

    // New digit enters at the top; after NDIG shifts the LSB digit has
    // reached bit 0. With a single digit the sum is the whole result.
    if (DIGIT == WIDTH) begin : g_single
        assign res_shift = sum_dig;
    end else begin : g_multi
        assign res_shift = {sum_dig, res_q[WIDTH-1:DIGIT]};
    end

    // Next-state decode.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path
        // leaves it unassigned; otherwise synthesis infers a latch.
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)          state_d = RUN;
            RUN:     if (last_digit)      state_d = DONE;
            DONE:    if (out_ready)       state_d = IDLE;
            default:                      state_d = IDLE;
        endcase
    end

    // Datapath next-state.
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        carry_d = carry_q;
        zero_d  = zero_q;
        cnt_d   = cnt_q;
        flags_d = flags_q;

        if (state_q == IDLE && accept) begin
            a_d     = a;
            b_d     = sub ? ~b : b;
            carry_d = sub;
            cnt_d   = '0;
            zero_d  = 1'b1;
        end else if (state_q == RUN) begin
            a_d     = a_q >> DIGIT;
            b_d     = b_q >> DIGIT;
            res_d   = res_shift;
            carry_d = dig_cout;
            zero_d  = zero_q & (sum_dig == '0);
            cnt_d   = cnt_q + CW'(1);
            if (last_digit) begin
                // Final digit holds bit WIDTH-1, so its carries give C and V.
                flags_d.n = sum_dig[DIGIT-1];
                flags_d.z = zero_q & (sum_dig == '0);
                flags_d.c = dig_cout;
                flags_d.v = dig_c_msb_in ^ dig_cout;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (!reset_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            cnt_q   <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
            cnt_q   <= cnt_d;
            flags_q <= flags_d;
        end
    end

endmodule

// File: tb/tb_addsub_serial.sv
// ----------------------------------------------------------------------------
// tb_addsub_serial
// Self-checking bench for addsub_serial with WIDTH=8, DIGIT=2 (NDIG=4).
// Expected values come from directed constants or an arithmetic reference
// model (integer add/sub with signed-overflow rules).
// ----------------------------------------------------------------------------
module tb_addsub_serial;

    localparam int WIDTH = 8;
    localparam int DIGIT = 2;
    localparam int NDIG  = WIDTH / DIGIT;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [3:0]       flags;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    addsub_serial #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .sub      (sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .flags    (flags)
    );

    // Reference: plain integer arithmetic, C as carry / NOT-borrow,
    // V from operand and result signs.
    function automatic void model(input logic [7:0] ma, input logic [7:0] mb,
                                  input logic ms, output logic [7:0] r,
                                  output logic [3:0] f);
        int ua, ub, s;
        logic n, z, c, v;
        ua = int'(ma);
        ub = int'(mb);
        if (!ms) begin
            s = ua + ub;
            r = 8'(s);
            c = (s > 255);
            v = (ma[7] == mb[7]) && (r[7] != ma[7]);
        end else begin
            s = ua - ub;
            r = 8'(s);
            c = (ua >= ub);
            v = (ma[7] != mb[7]) && (r[7] != ma[7]);
        end
        n = r[7];
        z = (r == 8'h00);
        f = {n, z, c, v};
    endfunction

    // Starts at a negedge; returns at the negedge where out_valid is seen.
    task automatic run_op(input logic [7:0] op_a, input logic [7:0] op_b,
                          input logic op_sub, output logic [7:0] r,
                          output logic [3:0] f, output int edges,
                          output bit ok);
        int w;
        ok    = 1'b1;
        edges = 0;
        w     = 0;
        while (!in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            ok = 1'b0;
            r  = 'x;
            f  = 'x;
            return;
        end
        a        = op_a;
        b        = op_b;
        sub      = op_sub;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        // Scramble operands: only the accepted values may matter.
        a   = 8'($urandom);
        b   = 8'($urandom);
        sub = 1'($urandom);
        while (edges < 100) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (out_valid) break;
        end
        if (!out_valid) ok = 1'b0;
        r = result;
        f = flags;
    endtask

    task automatic release_out(input int stall);
        repeat (stall) @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        sub       = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        checks++;
        if (result !== 8'h00) begin
            errors++;
            $display("FAIL reset_result: got %h expected 00", result);
        end
        checks++;
        if (flags !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 0000", flags);
        end
        reset_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
    endtask

    // Directed op against fixed expected values, including latency.
    task automatic directed(input string name, input logic [7:0] op_a,
                            input logic [7:0] op_b, input logic op_sub,
                            input logic [7:0] exp_r, input logic [3:0] exp_f);
        logic [7:0] r;
        logic [3:0] f;
        int         edges;
        bit         ok;
        run_op(op_a, op_b, op_sub, r, f, edges, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s_timeout: got no out_valid expected out_valid", name);
        end
        checks++;
        if (r !== exp_r) begin
            errors++;
            $display("FAIL %s_result: got %h expected %h", name, r, exp_r);
        end
        checks++;
        if (f !== exp_f) begin
            errors++;
            $display("FAIL %s_flags: got %b expected %b", name, f, exp_f);
        end
        checks++;
        if (edges != NDIG) begin
            errors++;
            $display("FAIL %s_latency: got %0d edges expected %0d", name, edges, NDIG);
        end
        release_out(0);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_handoff: got in_ready=%b out_valid=%b expected 1/0",
                     name, in_ready, out_valid);
        end
    endtask

    task automatic test_add_overflow();
        directed("add_ovf", 8'h7F, 8'h01, 1'b0, 8'h80, 4'b1001);
    endtask

    task automatic test_equal_sub();
        directed("eq_sub", 8'h05, 8'h05, 1'b1, 8'h00, 4'b0110);
    endtask

    task automatic test_borrow();
        directed("borrow", 8'h00, 8'h01, 1'b1, 8'hFF, 4'b1000);
        directed("sub_ovf", 8'h80, 8'h01, 1'b1, 8'h7F, 4'b0011);
    endtask

    task automatic test_backpressure();
        logic [7:0] r0, exp_r;
        logic [3:0] f0, exp_f;
        int         edges;
        bit         ok;
        model(8'h3C, 8'h5A, 1'b0, exp_r, exp_f);
        run_op(8'h3C, 8'h5A, 1'b0, r0, f0, edges, ok);
        checks++;
        if (!ok || r0 !== exp_r || f0 !== exp_f) begin
            errors++;
            $display("FAIL bp_first: got ok=%b %h/%b expected %h/%b",
                     ok, r0, f0, exp_r, exp_f);
        end
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'($urandom);
            a        = 8'($urandom);
            b        = 8'($urandom);
            sub      = 1'($urandom);
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
                result !== exp_r || flags !== exp_f) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got ov=%b ir=%b %h/%b expected 1/0 %h/%b",
                         i, out_valid, in_ready, result, flags, exp_r, exp_f);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: got in_ready=%b out_valid=%b expected 1/0",
                     in_ready, out_valid);
        end
    endtask

    task automatic test_reset_mid_run();
        a        = 8'h12;
        b        = 8'h34;
        sub      = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);      // acceptance edge
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);      // first RUN edge
        @(negedge clk);      // inside the 2nd RUN cycle
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || result !== 8'h00) begin
            errors++;
            $display("FAIL midrun_reset: got out_valid=%b result=%h expected 0/00",
                     out_valid, result);
        end
        reset_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrun_release: got in_ready=%b out_valid=%b expected 1/0",
                     in_ready, out_valid);
        end
        directed("post_reset", 8'hFF, 8'h01, 1'b0, 8'h00, 4'b0110);
    endtask

    task automatic test_random();
        logic [7:0] ra, rb, r, exp_r;
        logic       rs;
        logic [3:0] f, exp_f;
        int         edges;
        int         n_out;
        bit         ok;
        n_out = 0;
        for (int i = 0; i < 1000; i++) begin
            ra        = 8'($urandom);
            rb        = 8'($urandom);
            rs        = 1'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            model(ra, rb, rs, exp_r, exp_f);
            run_op(ra, rb, rs, r, f, edges, ok);
            if (ok) n_out++;
            checks++;
            if (!ok || r !== exp_r || f !== exp_f) begin
                errors++;
                $display("FAIL rand[%0d] %h %s %h: got ok=%b %h/%b expected %h/%b",
                         i, ra, rs ? "-" : "+", rb, ok, r, f, exp_r, exp_f);
            end
            release_out($urandom_range(0, 3));
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL rand_handoff[%0d]: got out_valid=%b in_ready=%b expected 0/1",
                         i, out_valid, in_ready);
            end
        end
        checks++;
        if (n_out != 1000) begin
            errors++;
            $display("FAIL rand_count: got %0d results expected 1000", n_out);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_add_overflow();
        test_equal_sub();
        test_borrow();
        test_backpressure();
        test_reset_mid_run();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/addsub_serial.md
Name: addsub_serial

Overview:
- Parametrised digit-serial adder/subtractor. Computes a+b or a-b on WIDTH-bit operands, DIGIT bits per clock, over WIDTH/DIGIT cycles.
- Produces ARM-style NZCV flags.
- Sits in the ALU datapath as the area-lean add/sub unit. It uses ready/valid handshakes on both sides so it can stall behind a slow consumer.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of DIGIT.
- DIGIT, 4, bits processed per cycle; 1 <= DIGIT <= WIDTH.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset_n  input  1  synchronous, active-low reset.
- in_valid  input  1  operand request valid.
- in_ready  output  1  unit can accept an operation.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- sub  input  1  0 = a+b, 1 = a-b, implemented as a + ~b + 1.
- out_valid  output  1  result/flags valid.
- out_ready  input  1  consumer takes result.
- result  output  WIDTH  sum/difference, modulo 2^WIDTH.
- flags  output  4  {N,Z,C,V}.

Behaviour:
- NDIG = WIDTH/DIGIT. The digit counter is $clog2(NDIG) bits wide, minimum 1.
- Reset (reset_n=0 at a rising edge):
  - state returns to IDLE;
  - result, flags and the internal shift/carry/counter registers are cleared to 0;
  - out_valid=0.
  - in_ready=1 from the first cycle after reset is released.
  - Reset has priority over all other events, including mid-RUN and DONE. An in-flight operation is discarded with no output.
- FSM states: IDLE, RUN, DONE. Outputs are registered or decoded from state only; there is no combinational path from input to output.
- IDLE: in_ready=1, out_valid=0.
  - On in_valid&&in_ready, latch a and (sub ? ~b : b), set carry=sub, count=0, zero_acc=1, then go to RUN.
- RUN: in_ready=0, out_valid=0. Each cycle:
  - add the low DIGIT bits of the A/B shift registers plus carry;
  - shift the sum digit into the top of the result register (LSB digit first);
  - shift A/B right by DIGIT;
  - update carry;
  - zero_acc &= (sum digit == 0);
  - count++.
  - On the cycle count==NDIG-1, flags are captured from the final digit and the state goes to DONE.
- Flag rules:
  - N = result[WIDTH-1].
  - Z = zero_acc including the final digit.
  - C = carry out of bit WIDTH-1. For subtraction this is NOT-borrow (ARM convention).
  - V = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
- DONE: out_valid=1; result and flags are held stable while out_ready=0, for any duration.
  - On out_valid&&out_ready the state goes to IDLE.
  - No same-cycle accept: in_ready rises the cycle after the handoff.
- Latency and throughput:
  - Acceptance edge E. out_valid is first high in the cycle after edge E+NDIG.
  - Minimum throughput is one operation per NDIG+2 cycles.
- Input handling:
  - a, b and sub are sampled only at acceptance; changes while busy are ignored.
  - in_valid is ignored unless the state is IDLE.
- Boundary cases:
  - DIGIT==WIDTH gives NDIG=1: RUN lasts one cycle.
  - Arithmetic wraps silently; overflow is reported only via V.
- Sequential logic uses always_ff; the next-state decode is a separate always_comb with a default-to-IDLE arm.

Decomposition:
- Package addsub_pkg holds:
  - flags_t: packed struct {logic n, z, c, v}, matching port order;
  - state_t: enum {IDLE, RUN, DONE};
  - the flag bit index localparams.
- One sub-module, addsub_digit (combinational, parameter DIGIT), takes (a_dig, b_dig, cin) and returns (sum_dig, cout, c_msb_in).
  - c_msb_in is the carry into the digit MSB, used for V.
  - It is a ripple of the existing fullAdder_1bit cells, generated DIGIT times.

Test Plan:
All scenarios use WIDTH=8, DIGIT=2, so NDIG=4.
- Add overflow: a=8'h7F, b=8'h01, sub=0 -> result=8'h80, flags N=1 Z=0 C=0 V=1. out_valid first high exactly 4 cycles after the acceptance edge.
- Equal subtract: a=8'h05, b=8'h05, sub=1 -> result=8'h00, N=0 Z=1 C=1 V=0.
- Borrow: a=8'h00, b=8'h01, sub=1 -> result=8'hFF, N=1 Z=0 C=0 V=0. Then a=8'h80, b=8'h01, sub=1 -> result=8'h7F, N=0 Z=0 C=1 V=1.
- Backpressure: hold out_ready=0 for 10 cycles in DONE, and toggle in_valid, a and b -> result, flags and out_valid stay unchanged and in_ready=0. Assert out_ready -> in_ready=1 on the next cycle, and out_valid=0.
- Reset mid-RUN: drive reset_n=0 for one edge during the 2nd RUN cycle -> out_valid=0 and result=0 after that edge, in_ready=1 after release. A subsequent 8'hFF+8'h01 -> result=8'h00, N=0 Z=1 C=1 V=0.
- Random regression: 1000 random a, b and sub values with random out_ready stalls -> each result and flag set matches the reference model, with no lost or duplicated transactions.
